// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel TX path.
// The header byte order is width LSB, width MSB, height LSB, height MSB.
package sobel_pkg;

    typedef logic [15:0] dim_t;

    typedef enum logic [1:0] {IDLE, HDR, STREAM, DONE} tx_state_t;

    localparam int HDR_BYTES = 4;

    function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input dim_t w, input dim_t h);
        case (idx)
            2'd0:    hdr_byte = w[7:0];
            2'd1:    hdr_byte = w[15:8];
            2'd2:    hdr_byte = h[7:0];
            default: hdr_byte = h[15:8];
        endcase
    endfunction

endpackage

// File: rtl/sobel_fifo_sync.sv
// Single-clock BRAM FIFO with a registered read port, which gives one cycle of read latency.
// Each pointer carries an extra wrap bit so that full and empty can be told apart.
module sobel_fifo_sync #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 2048,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 full,
    output logic                 empty
);

    localparam logic [ADDR_BITS:0] PTR_ONE = 1;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [ADDR_BITS:0]   wptr;
    logic [ADDR_BITS:0]   rptr;
    logic                 wr_ok;
    logic                 rd_ok;

    assign empty = (wptr == rptr);
    assign full  = (wptr[ADDR_BITS] != rptr[ADDR_BITS]) &&
                   (wptr[ADDR_BITS-1:0] == rptr[ADDR_BITS-1:0]);
    assign rd_ok = rd_en && !empty;
    // A read in the same cycle frees a slot, so a write at full still lands.
    assign wr_ok = wr_en && (!full || rd_ok);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr[ADDR_BITS-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            rd_data <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + PTR_ONE;
            end
            if (rd_ok) begin
                rptr    <= rptr + PTR_ONE;
                rd_data <= mem[rptr[ADDR_BITS-1:0]];
            end
        end
    end

endmodule

// File: rtl/sobel_tx_buffer.sv
// Sobel output stage. It sends a 4-byte image header, then the buffered pixels, to the UART TX.
// When SOBEL_TX_THRESH_EN is defined, a thresh port is added and each pixel is binarised before it is stored.
//
// state  | meaning
// IDLE   | waiting for start
// HDR    | sending width/height header bytes
// STREAM | forwarding FIFO bytes to tx until the image is complete
// DONE   | one-cycle done pulse
module sobel_tx_buffer
    import sobel_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 2048,
    parameter int ADDR_BITS  = $clog2(FIFO_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [15:0]          width,
    input  logic [15:0]          height,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [31:0]          pix_count
`ifdef SOBEL_TX_THRESH_EN
   ,input  logic [DATA_BITS-1:0] thresh
`endif
);

    tx_state_t            state;
    dim_t                 width_q;
    dim_t                 height_q;
    logic [31:0]          total_q;
    logic [31:0]          in_cnt;
    logic [1:0]           hdr_idx;
    logic [DATA_BITS-1:0] hdr_q;
    logic [DATA_BITS-1:0] fifo_rd_data;
    logic [DATA_BITS-1:0] wr_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_wr;
    logic                 fifo_rd;
    logic                 in_live;
    logic                 in_act;
    logic                 tx_hs;
    logic                 stream_end;

    assign in_live  = ((state == HDR) || (state == STREAM)) && (in_cnt < total_q);
    assign in_ready = in_live && !fifo_full;
    assign in_act   = in_live && in_valid && !start;
    assign fifo_wr  = in_act && !fifo_full;
    assign tx_hs    = tx_valid && tx_ready;
    // The FIFO read register is the output register, so tx_data reads it directly in STREAM.
    assign fifo_rd  = (state == STREAM) && !start && !fifo_empty && (!tx_valid || tx_ready);
    assign stream_end = (state == STREAM) && (in_cnt == total_q) && fifo_empty &&
                        (!tx_valid || tx_ready);
    assign tx_data  = (state == STREAM) ? fifo_rd_data : hdr_q;
    assign busy     = (state != IDLE);

`ifdef SOBEL_TX_THRESH_EN
    assign wr_data = (in_data >= thresh) ? '1 : '0;
`else
    assign wr_data = in_data;
`endif

    sobel_fifo_sync #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (FIFO_DEPTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (start),
        .wr_en   (fifo_wr),
        .wr_data (wr_data),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            width_q   <= '0;
            height_q  <= '0;
            total_q   <= '0;
            in_cnt    <= '0;
            hdr_idx   <= '0;
            hdr_q     <= '0;
            tx_valid  <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            pix_count <= '0;
        end else if (start) begin
            width_q   <= width;
            height_q  <= height;
            total_q   <= {16'd0, width} * {16'd0, height};
            in_cnt    <= '0;
            hdr_idx   <= '0;
            hdr_q     <= DATA_BITS'(hdr_byte(2'd0, width, height));
            tx_valid  <= 1'b1;
            done      <= 1'b0;
            overflow  <= 1'b0;
            pix_count <= '0;
            state     <= HDR;
        end else begin
            done <= 1'b0;
            // Bytes count toward the image even when dropped; the upstream path cannot stall.
            if (in_act) begin
                in_cnt <= in_cnt + 32'd1;
                if (fifo_full) begin
                    overflow <= 1'b1;
                end
            end
            case (state)
                IDLE: begin
                end
                HDR: begin
                    if (tx_hs) begin
                        if (hdr_idx == 2'(HDR_BYTES - 1)) begin
                            tx_valid <= 1'b0;
                            state    <= STREAM;
                        end else begin
                            hdr_idx <= hdr_idx + 2'd1;
                            hdr_q   <= DATA_BITS'(hdr_byte(hdr_idx + 2'd1, width_q, height_q));
                        end
                    end
                end
                STREAM: begin
                    if (tx_hs) begin
                        pix_count <= pix_count + 32'd1;
                    end
                    if (stream_end) begin
                        tx_valid <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else if (fifo_rd) begin
                        tx_valid <= 1'b1;
                    end else if (tx_ready) begin
                        tx_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_tx_buffer.sv
// Directed bench for sobel_tx_buffer. It uses a FIFO_DEPTH=8 instance so that overflow is easy to reach.
// The thresholding scenario is built only when SOBEL_TX_THRESH_EN is defined.
module tb_sobel_tx_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] width = '0;
    logic [15:0] height = '0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [31:0] pix_count;
`ifdef SOBEL_TX_THRESH_EN
    logic [7:0]  thresh = 8'h80;
`endif

    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc_g = 0;
    int         last_hs = 0;
    logic [7:0] rx_q [$];
    logic [7:0] pix_mem [16];

    always #5 clk = ~clk;

    sobel_tx_buffer #(.DATA_BITS(8), .FIFO_DEPTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .width     (width),
        .height    (height),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
`ifdef SOBEL_TX_THRESH_EN
        .thresh    (thresh),
`endif
        .pix_count (pix_count)
    );

    // Called at a negedge after the inputs are set. It logs any handshake that the next posedge will complete.
    task automatic tick();
        if (tx_valid && tx_ready) begin
            rx_q.push_back(tx_data);
            last_hs = cyc_g;
        end
        cyc_g++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; tx_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic pulse_start(input logic [15:0] w, input logic [15:0] h);
        in_valid = 1'b0; width = w; height = h; start = 1'b1;
        tick();
        start = 1'b0;
        rx_q.delete();
    endtask

    // mode 0: tx_ready held high; mode 1: tx_ready toggles 1/0. stop_rx>0 ends the run early.
    task automatic run_image(input int npix, input int mode, input int stop_rx,
                             output bit timed_out, output int viol, output int done_at);
        int pi = 0;
        int c = 0;
        bit prev_stall = 1'b0;
        logic [7:0] prev_data = '0;
        timed_out = 1'b0; viol = 0; done_at = -1;
        forever begin
            if (done === 1'b1) begin done_at = cyc_g; break; end
            if (stop_rx > 0 && rx_q.size() >= stop_rx) break;
            if (c >= 400) begin timed_out = 1'b1; break; end
            tx_ready = (mode == 0) ? 1'b1 : ((c % 2) == 0);
            in_valid = (pi < npix) && in_ready;
            in_data  = pix_mem[pi % 16];
            if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data)) viol++;
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (in_valid) pi++;
            tick();
            c++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        n_tests++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        n_tests++; if (pix_count !== 32'd0) begin n_fail++; $display("FAIL reset_pix_count: got %0d expected 0", pix_count); end
    endtask

    task automatic test_basic();
        logic [7:0] exp [$];
        bit to; int viol; int done_at;
        exp = '{8'h04, 8'h00, 8'h03, 8'h00};
        for (int i = 1; i <= 12; i++) begin pix_mem[i-1] = 8'(i); exp.push_back(8'(i)); end
        tx_ready = 1'b1;
        pulse_start(16'd4, 16'd3);
        n_tests++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL basic_hdr_valid: got %b expected 1", tx_valid); end
        n_tests++; if (tx_data !== 8'h04) begin n_fail++; $display("FAIL basic_hdr_first: got %h expected 04", tx_data); end
        run_image(12, 0, 0, to, viol, done_at);
        n_tests++; if (to) begin n_fail++; $display("FAIL basic_timeout: got timeout expected done"); end
        n_tests++;
        if (rx_q.size() != exp.size()) begin n_fail++; $display("FAIL basic_len: got %0d expected %0d", rx_q.size(), exp.size()); end
        else for (int i = 0; i < exp.size(); i++) begin
            n_tests++; if (rx_q[i] !== exp[i]) begin n_fail++; $display("FAIL basic_byte%0d: got %h expected %h", i, rx_q[i], exp[i]); end
        end
        n_tests++; if (done_at !== last_hs + 1) begin n_fail++; $display("FAIL basic_done_cycle: got %0d expected %0d", done_at, last_hs + 1); end
        n_tests++; if (pix_count !== 32'd12) begin n_fail++; $display("FAIL basic_pix_count: got %0d expected 12", pix_count); end
        tick();
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_stall();
        logic [7:0] exp [$];
        bit to; int viol; int done_at;
        exp = '{8'h04, 8'h00, 8'h03, 8'h00};
        for (int i = 1; i <= 12; i++) begin pix_mem[i-1] = 8'(i); exp.push_back(8'(i)); end
        pulse_start(16'd4, 16'd3);
        run_image(12, 1, 0, to, viol, done_at);
        n_tests++; if (to) begin n_fail++; $display("FAIL stall_timeout: got timeout expected done"); end
        n_tests++; if (viol != 0) begin n_fail++; $display("FAIL stall_stable: got %0d changes expected 0", viol); end
        n_tests++;
        if (rx_q.size() != exp.size()) begin n_fail++; $display("FAIL stall_len: got %0d expected %0d", rx_q.size(), exp.size()); end
        else for (int i = 0; i < exp.size(); i++) begin
            n_tests++; if (rx_q[i] !== exp[i]) begin n_fail++; $display("FAIL stall_byte%0d: got %h expected %h", i, rx_q[i], exp[i]); end
        end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL stall_overflow: got %b expected 0", overflow); end
        n_tests++; if (pix_count !== 32'd12) begin n_fail++; $display("FAIL stall_pix_count: got %0d expected 12", pix_count); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp [$];
        bit to; int viol; int done_at;
        exp = '{8'h0A, 8'h00, 8'h01, 8'h00};
        for (int i = 0; i < 8; i++) exp.push_back(8'(8'hA0 + i));
        tx_ready = 1'b0;
        pulse_start(16'd10, 16'd1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = 8'(8'hA0 + i);
            tick();
            if (i == 7) begin
                n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_in_ready: got %b expected 0", in_ready); end
            end
        end
        in_valid = 1'b0;
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        run_image(0, 0, 0, to, viol, done_at);
        n_tests++; if (to) begin n_fail++; $display("FAIL ovf_timeout: got timeout expected done"); end
        n_tests++;
        if (rx_q.size() != exp.size()) begin n_fail++; $display("FAIL ovf_len: got %0d expected %0d", rx_q.size(), exp.size()); end
        else for (int i = 0; i < exp.size(); i++) begin
            n_tests++; if (rx_q[i] !== exp[i]) begin n_fail++; $display("FAIL ovf_byte%0d: got %h expected %h", i, rx_q[i], exp[i]); end
        end
        n_tests++; if (pix_count !== 32'd8) begin n_fail++; $display("FAIL ovf_pix_count: got %0d expected 8", pix_count); end
    endtask

    task automatic test_zero_size();
        logic [7:0] exp [$];
        bit to; int viol; int done_at;
        exp = '{8'h00, 8'h00, 8'h05, 8'h00};
        tx_ready = 1'b1;
        pulse_start(16'd0, 16'd5);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'h55;
            tick();
        end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL zero_in_ready: got %b expected 0", in_ready); end
        in_valid = 1'b0;
        run_image(0, 0, 0, to, viol, done_at);
        n_tests++; if (to) begin n_fail++; $display("FAIL zero_timeout: got timeout expected done"); end
        n_tests++;
        if (rx_q.size() != exp.size()) begin n_fail++; $display("FAIL zero_len: got %0d expected %0d", rx_q.size(), exp.size()); end
        else for (int i = 0; i < exp.size(); i++) begin
            n_tests++; if (rx_q[i] !== exp[i]) begin n_fail++; $display("FAIL zero_byte%0d: got %h expected %h", i, rx_q[i], exp[i]); end
        end
        n_tests++; if (pix_count !== 32'd0) begin n_fail++; $display("FAIL zero_pix_count: got %0d expected 0", pix_count); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL zero_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_restart();
        logic [7:0] exp [$];
        bit to; int viol; int done_at;
        exp = '{8'h02, 8'h00, 8'h02, 8'h00, 8'h21, 8'h22, 8'h23, 8'h24};
        for (int i = 1; i <= 12; i++) pix_mem[i-1] = 8'(i);
        tx_ready = 1'b1;
        pulse_start(16'd4, 16'd3);
        run_image(12, 0, 9, to, viol, done_at);
        for (int i = 0; i < 4; i++) pix_mem[i] = 8'(8'h21 + i);
        pulse_start(16'd2, 16'd2);
        run_image(4, 0, 0, to, viol, done_at);
        n_tests++; if (to) begin n_fail++; $display("FAIL restart_timeout: got timeout expected done"); end
        n_tests++;
        if (rx_q.size() != exp.size()) begin n_fail++; $display("FAIL restart_len: got %0d expected %0d", rx_q.size(), exp.size()); end
        else for (int i = 0; i < exp.size(); i++) begin
            n_tests++; if (rx_q[i] !== exp[i]) begin n_fail++; $display("FAIL restart_byte%0d: got %h expected %h", i, rx_q[i], exp[i]); end
        end
        n_tests++; if (pix_count !== 32'd4) begin n_fail++; $display("FAIL restart_pix_count: got %0d expected 4", pix_count); end

        for (int i = 1; i <= 12; i++) pix_mem[i-1] = 8'(i);
        pulse_start(16'd4, 16'd3);
        run_image(12, 0, 7, to, viol, done_at);
        rst_n = 1'b0;
        tick();
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_tx_valid: got %b expected 0", tx_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_tests++; if (pix_count !== 32'd0) begin n_fail++; $display("FAIL midrst_pix_count: got %0d expected 0", pix_count); end
        start = 1'b1; width = 16'd4; height = 16'd3;
        tick();
        start = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_over_start: got busy %b expected 0", busy); end
        rst_n = 1'b1;
        tick();
    endtask

`ifdef SOBEL_TX_THRESH_EN
    task automatic test_thresh();
        logic [7:0] exp [$];
        bit to; int viol; int done_at;
        exp = '{8'h04, 8'h00, 8'h01, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00};
        pix_mem[0] = 8'h7F; pix_mem[1] = 8'h80; pix_mem[2] = 8'hFF; pix_mem[3] = 8'h00;
        tx_ready = 1'b1;
        pulse_start(16'd4, 16'd1);
        run_image(4, 0, 0, to, viol, done_at);
        n_tests++; if (to) begin n_fail++; $display("FAIL thresh_timeout: got timeout expected done"); end
        n_tests++;
        if (rx_q.size() != exp.size()) begin n_fail++; $display("FAIL thresh_len: got %0d expected %0d", rx_q.size(), exp.size()); end
        else for (int i = 0; i < exp.size(); i++) begin
            n_tests++; if (rx_q[i] !== exp[i]) begin n_fail++; $display("FAIL thresh_byte%0d: got %h expected %h", i, rx_q[i], exp[i]); end
        end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_zero_size();
        test_restart();
`ifdef SOBEL_TX_THRESH_EN
        test_thresh();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no summary by 200000 expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
